seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Multiplexed multi-digit 7-segment display driver: captures a packed vector of 4-bit digit codes, decodes one digit per scan slot (BCD or hex), and time-multiplexes segment and digit-enable lines. Sits between datapath counters/registers and the board display pins. It adds configurable digit count, refresh rate, hex mode, output polarity, leading-zero suppression, decimal points, error flagging, and tear-free frame-synchronous updates.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- CLK_DIV, 50000, clock cycles per digit slot (>= 2)
- HEX_MODE, 0, 1: codes 10-15 display A,b,C,d,E,F; 0: codes 10-15 are invalid
- ACTIVE_LOW, 0, 1: seg, dp, an all inverted at the pins
- LZ_SUPPRESS, 1, 1: blank leading zeros (digit 0 never suppressed)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  capture value/dp_in into pending register this cycle
- value  in  4*DIGITS  digit codes, digit i = value[4i+3:4i], digit 0 least significant
- dp_in  in  DIGITS  decimal point per digit
- enable  in  1  0 blanks display; scan keeps running
- seg  out  7  {a,b,c,d,e,f,g}, logical 1 = lit before polarity
- dp  out  1  decimal point of active digit
- an  out  DIGITS  one-hot digit enable, bit i = digit i
- digit_idx  out  clog2(DIGITS) (min 1)  digit currently being scanned
- frame_done  out  1  one-cycle pulse on final tick of digit DIGITS-1
- err  out  1  sticky: an invalid code reached the display register

## Operation
- Prescaler counts 0..CLK_DIV-1 and wraps; tick = (prescaler == CLK_DIV-1).
- On tick, digit_idx increments and wraps DIGITS-1 -> 0. boundary = tick && digit_idx == DIGITS-1; frame_done = boundary (registered and asserted in the same cycle as the boundary state).
- load writes pending register (value, dp_in). Display register <= pending only on boundary. When load and boundary coincide, the newly loaded data is transferred. A load mid-frame never alters the current frame.
- Decode (logical polarity): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- HEX_MODE=0, codes 10-15: seg=0000001 ("-").
  - err sets on the boundary that transfers any invalid code.
  - err clears on the boundary that transfers an all-valid word, or on reset.
  - err is never set when HEX_MODE=1.
- Leading-zero suppression: digit i>0 is blank when its code and every more-significant code are 0. A blank digit drives seg=0000000 and its an bit inactive; dp still follows dp register (an stays active only if dp lit).
- enable=0: seg, dp, an all inactive.
- ACTIVE_LOW inverts seg, dp, an after all of the above.

## Timing
- Reset (rst high at an edge): prescaler=0, digit_idx=0, pending=0, display=0, frame_done=0, err=0, seg/dp/an inactive (all 0, or all 1 if ACTIVE_LOW).
- seg, dp, an are registered from (digit_idx, display, enable) every cycle. They lag digit_idx and display by exactly one cycle.
- Each digit is driven for exactly CLK_DIV cycles. The frame period is DIGITS*CLK_DIV cycles.
- Latency, load to pins: transfer at the next boundary (same cycle if coincident), plus 1 cycle to the pins.
- rst mid-frame: all state returns to reset values on that edge. A pending load in the same cycle is discarded.
- DIGITS=1: digit_idx stays 0, every tick is a boundary, and an is constant active.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=4, HEX_MODE=0, ACTIVE_LOW=0, LZ_SUPPRESS=1 unless stated.
- Reset: hold rst 3 cycles -> seg=0, an=0000, dp=0, err=0. The cycle after release -> an=0001, seg=1111110. digit_idx sequence is 0,1,2,3,0 every 4 cycles. frame_done pulses every 16 cycles.
- Load 0x1234 mid-frame -> the current frame is unchanged. After the next frame_done: digit3 shows 0110000, digit2 1101101, digit1 1111001, digit0 0110011, with an 1000/0100/0010/0001 for 4 cycles each.
- Load 0x0070, dp_in=0100 -> digits 3 and 2: an=0, seg=0, except digit2 has an active with dp=1. Digit1 shows 1110000; digit0 shows 1111110.
- Load 0x00A5 -> digit1 shows 0000001, and err=1 after the transfer. Load 0x0005 -> err=0 after the next boundary. Repeat with HEX_MODE=1 -> digit1 shows 1110111 and err stays 0.
- Load 0x8888 asserted exactly on the boundary cycle -> digit 0 in the next frame shows 1111111. Assert rst mid-frame -> outputs go inactive next edge and digit_idx=0.
- ACTIVE_LOW=1 with value 0x0001 -> digit0 seg=1001111, an=1110. Then enable=0 -> seg=1111111, an=1111, dp=1, and digit_idx keeps advancing.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Multiplexed multi-digit 7-segment display driver. A pending register
//   captures digit codes on load; the display register takes them only on the
//   last tick of the final digit so a frame is never torn. One digit is driven
//   per scan slot of CLK_DIV cycles.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture value/dp_in into the pending register
//   value, dp_in      4-bit digit codes (digit 0 least significant), decimal points
//   enable            0 blanks the pins while the scan keeps running
//   seg, dp, an       registered segment {a..g}, decimal point, one-hot digit enable
//   digit_idx         digit currently being scanned
//   frame_done        high during the final tick of digit DIGITS-1
//   err               sticky flag: an invalid code reached the display register
module seven_seg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int CLK_DIV     = 50000,
   parameter int HEX_MODE    = 0,
   parameter int ACTIVE_LOW  = 0,
   parameter int LZ_SUPPRESS = 1,
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  enable,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic [IW-1:0]         digit_idx,
   output logic                  frame_done,
   output logic                  err
);

   localparam int   PW  = $clog2(CLK_DIV);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [PW-1:0]         presc;
   logic [PW-1:0]         presc_nxt;
   logic [IW-1:0]         idx_nxt;
   logic                  tick;
   logic                  boundary;

   logic [4*DIGITS-1:0]   pend_val;
   logic [DIGITS-1:0]     pend_dp;
   logic [4*DIGITS-1:0]   disp_val;
   logic [DIGITS-1:0]     disp_dp;

   logic [4*DIGITS-1:0]   xfer_val;
   logic [DIGITS-1:0]     xfer_dp;
   logic                  xfer_bad;

   logic [3:0]            cur_code;
   logic                  cur_dp;
   logic                  cur_blank;
   logic                  zero_run;
   logic [6:0]            seg_l;
   logic                  dp_l;
   logic [DIGITS-1:0]     an_l;

   function automatic logic [6:0] dec7(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         4'd10:   s = 7'b1110111;
         4'd11:   s = 7'b0011111;
         4'd12:   s = 7'b1001110;
         4'd13:   s = 7'b0111101;
         4'd14:   s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      // Without hex support, codes above 9 show a single dash.
      if (HEX_MODE == 0 && code > 4'd9) s = 7'b0000001;
      return s;
   endfunction

   assign tick      = (presc == PW'(CLK_DIV - 1));
   assign boundary  = tick && (digit_idx == IW'(DIGITS - 1));
   assign presc_nxt = tick ? '0 : presc + 1'b1;
   assign idx_nxt   = !tick ? digit_idx :
                      (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;

   // A load coinciding with the boundary bypasses the pending register so the
   // freshest data goes straight to the display.
   assign xfer_val = load ? value : pend_val;
   assign xfer_dp  = load ? dp_in : pend_dp;

   always_comb begin
      xfer_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (HEX_MODE == 0 && xfer_val[4*i +: 4] > 4'd9) xfer_bad = 1'b1;
   end

   // Walk from the most significant digit down; zero_run stays set while every
   // code seen so far is zero, which marks the current digit as a leading zero.
   always_comb begin
      cur_code  = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_val[4*i +: 4] == 4'd0);
         if (digit_idx == IW'(i)) begin
            cur_code  = disp_val[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = (LZ_SUPPRESS != 0) && (i > 0) && zero_run;
         end
      end
   end

   // A blanked digit keeps its anode on only when its decimal point is lit.
   always_comb begin
      seg_l = (enable && !cur_blank) ? dec7(cur_code) : 7'b0;
      dp_l  = enable && cur_dp;
      an_l  = (enable && (!cur_blank || cur_dp)) ? (DIGITS'(1) << digit_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc      <= '0;
         digit_idx  <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         disp_val   <= '0;
         disp_dp    <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         seg        <= {7{POL}};
         dp         <= POL;
         an         <= {DIGITS{POL}};
      end else begin
         presc     <= presc_nxt;
         digit_idx <= idx_nxt;
         // frame_done is registered from the next-state boundary so it is high
         // in the same cycle the boundary state is present.
         frame_done <= (presc_nxt == PW'(CLK_DIV - 1)) && (idx_nxt == IW'(DIGITS - 1));
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         if (boundary) begin
            disp_val <= xfer_val;
            disp_dp  <= xfer_dp;
            err      <= xfer_bad;
         end
         seg <= seg_l ^ {7{POL}};
         dp  <= dp_l ^ POL;
         an  <= an_l ^ {DIGITS{POL}};
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver. Four instances share stimulus: default
// decimal mode, hex mode, active-low pins, and a single-digit build. Loads push
// the expected frame onto a queue; each frame check pops it at frame start.
module tb_seven_seg_scan_driver;

   typedef struct packed {
      logic [3:0][6:0] seg;
      logic [3:0][3:0] an;
      logic [3:0]      dp;
      logic            err;
   } frame_t;

   typedef struct packed {
      frame_t nh;
      frame_t hx;
   } rec_t;

   localparam logic [6:0] LUT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   logic        clk, rst, load, enable;
   logic [15:0] value;
   logic [3:0]  dp_in;

   logic [6:0] seg_m, seg_h, seg_a, seg_s;
   logic       dp_m, dp_h, dp_a, dp_s;
   logic [3:0] an_m, an_h, an_a;
   logic [0:0] an_s;
   logic [1:0] idx_m, idx_h, idx_a;
   logic       idx_s;
   logic       fd_m, fd_h, fd_a, fd_s;
   logic       err_m, err_h, err_a, err_s;

   int n_tests = 0;
   int n_fail  = 0;
   rec_t q[$];
   rec_t cur;

   seven_seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) u_m (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
      .seg(seg_m), .dp(dp_m), .an(an_m), .digit_idx(idx_m), .frame_done(fd_m), .err(err_m));
   seven_seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) u_h (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
      .seg(seg_h), .dp(dp_h), .an(an_h), .digit_idx(idx_h), .frame_done(fd_h), .err(err_h));
   seven_seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(1), .LZ_SUPPRESS(1)) u_a (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
      .seg(seg_a), .dp(dp_a), .an(an_a), .digit_idx(idx_a), .frame_done(fd_a), .err(err_a));
   seven_seg_scan_driver #(.DIGITS(1), .CLK_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) u_s (
      .clk(clk), .rst(rst), .load(load), .value(value[3:0]), .dp_in(dp_in[0:0]), .enable(enable),
      .seg(seg_s), .dp(dp_s), .an(an_s), .digit_idx(idx_s), .frame_done(fd_s), .err(err_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic frame_t build(input logic [15:0] v, input logic [3:0] dv, input bit hex);
      frame_t f;
      logic [3:0] code;
      logic z, blank;
      logic [6:0] s;
      f = '0;
      z = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         code  = v[4*i +: 4];
         z     = z && (code == 4'd0);
         blank = (i > 0) && z;
         s     = LUT[code];
         if (!hex && code > 4'd9) begin
            s     = 7'b0000001;
            f.err = 1'b1;
         end
         f.seg[i] = blank ? 7'b0 : s;
         f.an[i]  = (!blank || dv[i]) ? (4'b0001 << i) : 4'b0000;
         f.dp[i]  = dv[i];
      end
      return f;
   endfunction

   // Entered at the falling edge of the last cycle of the previous frame's
   // output window; samples the 16 output cycles of the next frame.
   task automatic check_frame(input bit en, input int ld_at, input logic [15:0] v, input logic [3:0] dv);
      int d;
      logic [11:0] e, eh;
      enable = en;
      if (q.size() > 0) cur = q.pop_front();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         d  = c / 4;
         e  = en ? {cur.nh.seg[d], cur.nh.an[d], cur.nh.dp[d]} : 12'h000;
         eh = en ? {cur.hx.seg[d], cur.hx.an[d], cur.hx.dp[d]} : 12'h000;
         n_tests++;
         if ({seg_m, an_m, dp_m} !== e) begin
            n_fail++; $display("FAIL pins_main c=%0d got %h exp %h", c, {seg_m, an_m, dp_m}, e);
         end
         n_tests++;
         if ({seg_h, an_h, dp_h} !== eh) begin
            n_fail++; $display("FAIL pins_hex c=%0d got %h exp %h", c, {seg_h, an_h, dp_h}, eh);
         end
         n_tests++;
         if ({seg_a, an_a, dp_a} !== (e ^ 12'hfff)) begin
            n_fail++; $display("FAIL pins_al c=%0d got %h exp %h", c, {seg_a, an_a, dp_a}, e ^ 12'hfff);
         end
         n_tests++;
         if (idx_m !== 2'(((c + 1) / 4) % 4)) begin
            n_fail++; $display("FAIL digit_idx c=%0d got %0d exp %0d", c, idx_m, ((c + 1) / 4) % 4);
         end
         n_tests++;
         if (fd_m !== (c == 14)) begin
            n_fail++; $display("FAIL frame_done c=%0d got %b exp %b", c, fd_m, (c == 14));
         end
         if (c <= 14) begin
            n_tests++;
            if ({err_m, err_h, err_a} !== {cur.nh.err, 1'b0, cur.nh.err}) begin
               n_fail++; $display("FAIL err c=%0d got %b exp %b", c, {err_m, err_h, err_a}, {cur.nh.err, 1'b0, cur.nh.err});
            end
         end
         n_tests++;
         if ({an_s, idx_s, fd_s} !== {en, 1'b0, (c % 4 == 2)}) begin
            n_fail++; $display("FAIL single_digit c=%0d got %b exp %b", c, {an_s, idx_s, fd_s}, {en, 1'b0, (c % 4 == 2)});
         end
         load = (c == ld_at);
         if (c == ld_at) begin
            value = v;
            dp_in = dv;
            q.push_back('{nh: build(v, dv, 1'b0), hx: build(v, dv, 1'b1)});
         end
      end
   endtask

   // Leaves the bench at the falling edge one cycle after frame_done.
   task automatic sync_frame();
      int k;
      k = 0;
      while (fd_m !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (fd_m !== 1'b1) begin
         n_fail++; $display("FAIL frame_sync got %b exp 1 (timeout)", fd_m);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; enable = 1'b1;
      cur = '{nh: build(16'h0, 4'h0, 1'b0), hx: build(16'h0, 4'h0, 1'b1)};
      repeat (3) @(negedge clk);
      n_tests++;
      if ({seg_m, an_m, dp_m, err_m, fd_m, idx_m} !== 15'b0) begin
         n_fail++; $display("FAIL reset_main got %b exp 0", {seg_m, an_m, dp_m, err_m, fd_m, idx_m});
      end
      n_tests++;
      if ({seg_a, an_a, dp_a} !== 12'hfff) begin
         n_fail++; $display("FAIL reset_al got %h exp fff", {seg_a, an_a, dp_a});
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({an_m, seg_m} !== {4'b0001, 7'b1111110}) begin
         n_fail++; $display("FAIL first_digit got %b exp %b", {an_m, seg_m}, {4'b0001, 7'b1111110});
      end
      sync_frame();
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   task automatic test_mid_load();
      check_frame(1'b1, 6, 16'h1234, 4'h0);
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   task automatic test_lz_dp();
      check_frame(1'b1, 3, 16'h0070, 4'b0100);
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   task automatic test_err();
      check_frame(1'b1, 2, 16'h00A5, 4'h0);
      check_frame(1'b1, 9, 16'h0005, 4'h0);
      check_frame(1'b1, 12, 16'h00A5, 4'h0);
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   task automatic test_mid_reset();
      repeat (5) @(negedge clk);
      rst = 1'b1; load = 1'b1; value = 16'h9999; dp_in = 4'hf;
      @(negedge clk);
      n_tests++;
      if ({seg_m, an_m, dp_m, err_m, fd_m, idx_m} !== 15'b0) begin
         n_fail++; $display("FAIL mid_reset_main got %b exp 0", {seg_m, an_m, dp_m, err_m, fd_m, idx_m});
      end
      n_tests++;
      if ({seg_a, an_a, dp_a, err_a} !== 13'h1ffe) begin
         n_fail++; $display("FAIL mid_reset_al got %h exp 1ffe", {seg_a, an_a, dp_a, err_a});
      end
      rst = 1'b0; load = 1'b0;
      q.delete();
      cur = '{nh: build(16'h0, 4'h0, 1'b0), hx: build(16'h0, 4'h0, 1'b1)};
      sync_frame();
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   task automatic test_boundary_load();
      check_frame(1'b1, 14, 16'h8888, 4'h0);
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   task automatic test_enable();
      check_frame(1'b1, 5, 16'h0001, 4'h0);
      check_frame(1'b1, -1, 16'h0, 4'h0);
      check_frame(1'b0, -1, 16'h0, 4'h0);
      check_frame(1'b1, -1, 16'h0, 4'h0);
   endtask

   initial begin
      test_reset();
      test_mid_load();
      test_lz_dp();
      test_err();
      test_mid_reset();
      test_boundary_load();
      test_enable();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
